// File: rtl/mem_system.sv
// mem_system: word-addressed RAM, an output FIFO and a free-running cycle
// counter behind a single processor-style load/store port.
//
// Address map (adr[1:0] ignored):
//   adr[31:28] == 0  RAM word adr[log2(RAM_WORDS)+1:2]; upper bits alias
//   0xFFFF0000       FIFO data: write pushes, read returns 0
//   0xFFFF0004       STATUS: [0] empty, [1] full, [2] overflow (sticky),
//                    [12:8] occupancy; any write clears overflow
//   0xFFFF0008       CYCLE counter: +1 every edge, a write loads it
//   anything else    reads 0, writes ignored
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous active-high reset (RAM contents are kept)
//   adr        byte address
//   writedata  store data
//   memwrite   write strobe, acts on the rising edge
//   readdata   combinational read data for adr
//   out_data   FIFO head word (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts head; pop on out_valid && out_ready
module mem_system #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Word addresses (byte address >> 2) of the memory-mapped registers.
  localparam logic [29:0] FIFO_WADR   = 30'h3FFF_C000;
  localparam logic [29:0] STATUS_WADR = 30'h3FFF_C001;
  localparam logic [29:0] CYCLE_WADR  = 30'h3FFF_C002;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  logic [31:0]   ram_r [RAM_WORDS];
  logic [31:0]   fifo_r [FIFO_DEPTH];
  logic [CW-1:0] count_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          overflow_r;
  logic [31:0]   cycle_r;

  logic          ram_sel_s;
  logic          fifo_sel_s;
  logic          status_sel_s;
  logic          cycle_sel_s;
  logic [AW-1:0] ram_idx_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_req_s;
  logic          push_s;
  logic          drop_s;
  logic [31:0]   status_s;
  logic          unused_s;

  assign ram_sel_s    = (adr[31:28] == 4'h0);
  assign fifo_sel_s   = (adr[31:2] == FIFO_WADR);
  assign status_sel_s = (adr[31:2] == STATUS_WADR);
  assign cycle_sel_s  = (adr[31:2] == CYCLE_WADR);
  assign ram_idx_s    = adr[AW+1:2];
  assign unused_s     = ^adr[1:0];

  assign empty_s    = (count_r == {CW{1'b0}});
  assign full_s     = (count_r == DEPTH_C);
  assign out_valid  = ~empty_s;
  assign pop_s      = out_valid & out_ready;
  assign push_req_s = memwrite & fifo_sel_s;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign drop_s     = push_req_s & full_s & ~pop_s;

  assign status_s = {19'h0, 5'(count_r), 5'h0, overflow_r, full_s, empty_s};

  // RAM storage: no reset so contents survive it; writes blocked during reset.
  always_ff @(posedge clk) begin
    if (!reset && memwrite && ram_sel_s) begin
      ram_r[ram_idx_s] <= writedata;
    end
  end

  // FIFO storage: stale entries are harmless because pointers/count reset.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      fifo_r[wr_ptr_r] <= writedata;
    end
  end

  // FIFO control, overflow flag and cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      overflow_r <= 1'b0;
      cycle_r    <= 32'h0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (memwrite && status_sel_s) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (memwrite && cycle_sel_s) begin
        cycle_r <= writedata;
      end else begin
        cycle_r <= cycle_r + 32'h1;
      end
    end
  end

  // Read-data mux: pure function of adr and current state.
  always_comb begin
    readdata = 32'h0;
    if (ram_sel_s) begin
      readdata = ram_r[ram_idx_s];
    end else if (status_sel_s) begin
      readdata = status_s;
    end else if (cycle_sel_s) begin
      readdata = cycle_r;
    end else begin
      readdata = 32'h0;
    end
  end

  // Head word, forced to 0 while the FIFO is empty.
  always_comb begin
    out_data = 32'h0;
    if (empty_s) begin
      out_data = 32'h0;
    end else begin
      out_data = fifo_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_mem_system.sv
// tb_mem_system: directed, self-checking bench for mem_system with default
// parameters (RAM_WORDS=64, FIFO_DEPTH=4). Inputs change 1ns after a rising
// edge and outputs are sampled 1ns after the inputs settle.
module tb_mem_system;

  localparam logic [31:0] FIFO_A   = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_A = 32'hFFFF_0004;
  localparam logic [31:0] CYCLE_A  = 32'hFFFF_0008;

  logic        clk;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_cmp;
  int n_bad;

  logic [31:0] exp_q [4];

  mem_system #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One write on the next rising edge; returns 1ns after that edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    adr       = a;
    writedata = d;
    memwrite  = 1'b1;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    adr = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    adr       = 32'h0;
    writedata = 32'h0;
    memwrite  = 1'b0;
    out_ready = 1'b0;

    // Reset state; CYCLE holds at 0 across edges while reset is high.
    repeat (3) step();
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data", out_data, 32'h0);
    rd_check("rst_status", STATUS_A, 32'h0000_0001);
    rd_check("rst_cycle", CYCLE_A, 32'h0);
    reset = 1'b0;
    step();
    rd_check("cycle_after_rel", CYCLE_A, 32'h1);

    // RAM write, alias, out-of-range and unmapped reads.
    do_write(32'h0000_0010, 32'h1234_5678);
    rd_check("ram_rd", 32'h0000_0010, 32'h1234_5678);
    rd_check("ram_alias", 32'h0000_0110, 32'h1234_5678);
    rd_check("ram_low_bits", 32'h0000_0013, 32'h1234_5678);
    rd_check("unmapped_2000", 32'h2000_0000, 32'h0);
    rd_check("unmapped_ffff0010", 32'hFFFF_0010, 32'h0);
    do_write(32'h2000_0010, 32'hDEAD_BEEF);
    rd_check("ignored_wr", 32'h0000_0010, 32'h1234_5678);

    // Overflow scenario: push A..E with out_ready low.
    do_write(FIFO_A, 32'hA);
    check("push_valid", {31'h0, out_valid}, 32'h1);
    check("push_head", out_data, 32'hA);
    rd_check("fifo_rd_zero", FIFO_A, 32'h0);
    rd_check("status_1", STATUS_A, 32'h0000_0100);
    do_write(FIFO_A, 32'hB);
    do_write(FIFO_A, 32'hC);
    do_write(FIFO_A, 32'hD);
    rd_check("status_full", STATUS_A, 32'h0000_0402);
    do_write(FIFO_A, 32'hE);
    rd_check("status_ovf", STATUS_A, 32'h0000_0406);
    step();
    check("head_stable", out_data, 32'hA);
    out_ready = 1'b1;
    exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid%0d", i), {31'h0, out_valid}, 32'h1);
      check($sformatf("drain_data%0d", i), out_data, exp_q[i]);
      step();
    end
    out_ready = 1'b0;
    check("drained_valid", {31'h0, out_valid}, 32'h0);
    check("drained_data", out_data, 32'h0);
    rd_check("status_empty_ovf", STATUS_A, 32'h0000_0005);
    do_write(STATUS_A, 32'h0);
    rd_check("status_cleared", STATUS_A, 32'h0000_0001);

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 4; i++) do_write(FIFO_A, 32'h100 + i);
    rd_check("status_full2", STATUS_A, 32'h0000_0402);
    out_ready = 1'b1;
    do_write(FIFO_A, 32'h104);
    out_ready = 1'b0;
    rd_check("status_pushpop", STATUS_A, 32'h0000_0402);
    out_ready = 1'b1;
    exp_q = '{32'h101, 32'h102, 32'h103, 32'h104};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_data%0d", i), out_data, exp_q[i]);
      step();
    end
    out_ready = 1'b0;
    check("pp_empty", {31'h0, out_valid}, 32'h0);

    // Empty FIFO with push and pop requested together: only the push counts.
    out_ready = 1'b1;
    do_write(FIFO_A, 32'h55);
    out_ready = 1'b0;
    rd_check("empty_pushpop", STATUS_A, 32'h0000_0100);
    check("empty_pushpop_head", out_data, 32'h55);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Cycle counter load and wrap.
    do_write(CYCLE_A, 32'hFFFF_FFFE);
    rd_check("cycle_load", CYCLE_A, 32'hFFFF_FFFE);
    step();
    check("cycle_ffff", readdata, 32'hFFFF_FFFF);
    step();
    check("cycle_wrap", readdata, 32'h0);

    // Asynchronous reset mid-cycle with 3 entries queued.
    do_write(32'h0000_0020, 32'h0000_AAAA);
    for (int i = 0; i < 3; i++) do_write(FIFO_A, 32'h200 + i);
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    adr = CYCLE_A;
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", {31'h0, out_valid}, 32'h0);
    check("async_cycle", readdata, 32'h0);
    step();
    do_write(32'h0000_0020, 32'h0000_5555);
    do_write(FIFO_A, 32'h300);
    rd_check("rst_cycle_hold", CYCLE_A, 32'h0);
    rd_check("rst_status2", STATUS_A, 32'h0000_0001);
    reset = 1'b0;
    step();
    rd_check("cycle_after_rel2", CYCLE_A, 32'h1);
    rd_check("ram_survives", 32'h0000_0010, 32'h1234_5678);
    rd_check("ram_blocked_wr", 32'h0000_0020, 32'h0000_AAAA);
    check("post_rst_valid", {31'h0, out_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
